// File: rtl/apb_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// apb_cmd_arbiter
//
// Round-robin arbiter that shares a single APB master command port between
// NUM_REQ requesters. One command is latched at a time, forwarded to the
// master, and the grant is held until the APB transfer completes (m_done)
// or the WAIT phase times out. The owner then gets a one-cycle response
// pulse and priority rotates to the requester after it.
//
// Handshake semantics (all valid/ready pairs on this block):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The source holds valid and its payload stable until that edge; valid
//   must not depend on ready. On the requester side ready (req_rdy) is a
//   combinational function of req_vld while IDLE; on the master side valid
//   (m_cmd_vld) is registered and held until m_cmd_rdy is seen.
//
// Ports:
//   clk, rst     : rising-edge clock, asynchronous active-high reset
//   req_cmd      : packed {rw, addr, data} per requester, slice i*CMD_WIDTH
//   req_vld      : per-requester command valid
//   req_rdy      : one-hot acceptance strobe (Mealy, IDLE only)
//   rsp_vld      : one-hot, one-cycle completion pulse to the owner
//   rsp_rdata    : read data (0 for writes / timeouts), valid with rsp_vld
//   rsp_err      : timeout flag, valid with rsp_vld
//   m_cmd        : command to the APB master, valid with m_cmd_vld
//   m_cmd_vld    : master command valid (ISSUE)
//   m_cmd_rdy    : master accepts the command
//   m_rdata      : APB read data, sampled with m_done
//   m_done       : one-cycle completion pulse from the master
//   transfer     : master transfer enable (ISSUE and WAIT)
//   grant_id     : index of the current owner
//   busy         : high whenever the FSM is not IDLE
//   state_dbg    : raw FSM state for observation
// ---------------------------------------------------------------------------
module apb_cmd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int CMD_WIDTH  = DATA_WIDTH + ADDR_WIDTH + 1,
    parameter int TIMEOUT    = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd,
    input  logic [NUM_REQ-1:0]           req_vld,
    output logic [NUM_REQ-1:0]           req_rdy,
    output logic [NUM_REQ-1:0]           rsp_vld,
    output logic [DATA_WIDTH-1:0]        rsp_rdata,
    output logic                         rsp_err,
    output logic [CMD_WIDTH-1:0]         m_cmd,
    output logic                         m_cmd_vld,
    input  logic                         m_cmd_rdy,
    input  logic [DATA_WIDTH-1:0]        m_rdata,
    input  logic                         m_done,
    output logic                         transfer,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic [1:0]                   state_dbg
);

    localparam int GW  = $clog2(NUM_REQ);
    localparam int TCW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [GW-1:0]           ptr;
    logic [TCW-1:0]          tcnt;
    logic [CMD_WIDTH-1:0]    cmd_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;

    logic                    win_found;
    logic [GW-1:0]           win_idx;
    logic                    timeout_hit;
    logic                    cmd_is_write;
    logic [GW-1:0]           ptr_nx;

    // -----------------------------------------------------------------------
    // Round-robin search: first asserted req_vld at or above ptr, wrapping
    // modulo NUM_REQ (which need not be a power of two).
    // -----------------------------------------------------------------------
    always_comb begin : arb_search
        int cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!win_found && req_vld[GW'(cand)]) begin
                win_found = 1'b1;
                win_idx   = GW'(cand);
            end
        end
    end

    assign timeout_hit  = (tcnt == TCW'(TIMEOUT - 1));
    assign cmd_is_write = cmd_q[CMD_WIDTH-1];
    assign ptr_nx       = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. m_cmd_rdy only matters in ISSUE, m_done only in WAIT.
    // In WAIT, m_done takes precedence over a coincident timeout.
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (win_found) begin
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (m_cmd_rdy) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (m_done || timeout_hit) begin
                    state_nx = S_RESP;
                end
            end
            S_RESP: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers: latched command, owner, timeout counter, pointer
    // and the response captured at the end of WAIT.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= '0;
            tcnt        <= '0;
            cmd_q       <= '0;
            grant_id    <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        cmd_q    <= req_cmd[win_idx*CMD_WIDTH +: CMD_WIDTH];
                        grant_id <= win_idx;
                    end
                end
                S_WAIT: begin
                    tcnt <= tcnt + 1'b1;
                    if (m_done) begin
                        // Writes return no data.
                        rsp_rdata_q <= cmd_is_write ? '0 : m_rdata;
                        rsp_err_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                    end
                end
                S_RESP: begin
                    ptr  <= ptr_nx;
                    tcnt <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. req_rdy is the only Mealy output; it is also forced low while
    // rst is asserted so that every output reads 0 during reset even if a
    // requester keeps req_vld high.
    // -----------------------------------------------------------------------
    always_comb begin
        req_rdy = '0;
        if (!rst && (state == S_IDLE) && win_found) begin
            req_rdy[win_idx] = 1'b1;
        end
    end

    always_comb begin
        rsp_vld = '0;
        if (state == S_RESP) begin
            rsp_vld[grant_id] = 1'b1;
        end
    end

    assign rsp_rdata = (state == S_RESP) ? rsp_rdata_q : '0;
    assign rsp_err   = (state == S_RESP) ? rsp_err_q : 1'b0;
    assign m_cmd_vld = (state == S_ISSUE);
    assign m_cmd     = (state == S_ISSUE) ? cmd_q : '0;
    assign transfer  = (state == S_ISSUE) || (state == S_WAIT);
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_apb_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_cmd_arbiter
//
// Self-checking bench for apb_cmd_arbiter (NUM_REQ=4, TIMEOUT=16).
// A driver walks each transaction through its phases and checks the DUT
// against a reference model (round-robin rule from a pointer, response
// rules from rw / m_done / timeout). Expected responses are pushed into a
// queue; an independent monitor pops and compares on every rsp_vld.
// ---------------------------------------------------------------------------
module tb_apb_cmd_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int CW = DW + AW + 1;
  localparam int TO = 16;
  localparam int RW = N + 1 + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N*CW-1:0]      req_cmd = '0;
  logic [N-1:0]         req_vld = '0;
  logic [N-1:0]         req_rdy;
  logic [N-1:0]         rsp_vld;
  logic [DW-1:0]        rsp_rdata;
  logic                 rsp_err;
  logic [CW-1:0]        m_cmd;
  logic                 m_cmd_vld;
  logic                 m_cmd_rdy = 1'b0;
  logic [DW-1:0]        m_rdata = '0;
  logic                 m_done = 1'b0;
  logic                 transfer;
  logic [$clog2(N)-1:0] grant_id;
  logic                 busy;
  logic [1:0]           state_dbg;

  apb_cmd_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_cmd(req_cmd), .req_vld(req_vld), .req_rdy(req_rdy),
    .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_cmd(m_cmd), .m_cmd_vld(m_cmd_vld), .m_cmd_rdy(m_cmd_rdy),
    .m_rdata(m_rdata), .m_done(m_done), .transfer(transfer),
    .grant_id(grant_id), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard / model state ----------------
  int tests = 0;
  int fails = 0;
  int mptr  = 0;
  logic [CW-1:0] cmds [N];
  logic [RW-1:0] exp_q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Round-robin rule: first valid requester searching upward from ptr.
  function automatic int winner(input logic [N-1:0] vld, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (vld[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [CW-1:0] rand_cmd();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[CW-1:0];
  endfunction

  task automatic set_cmd(input int i, input logic [CW-1:0] c);
    cmds[i] = c;
    req_cmd[i*CW +: CW] = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_ctl"}, {52'd0, req_rdy, rsp_vld, rsp_err, transfer, busy, m_cmd_vld, grant_id}, 64'd0);
    chk({nm, "_mcmd"}, {19'd0, m_cmd}, 64'd0);
    chk({nm, "_rdata"}, {32'd0, rsp_rdata}, 64'd0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_vld   = '0;
    m_cmd_rdy = 1'b0;
    m_done    = 1'b0;
    #3;
    chk_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    mptr = 0;
    exp_q.delete();
  endtask

  // ---------------- driver: one full transaction ----------------
  // Starts #1 after an edge with the DUT in IDLE and req_vld already set.
  // done_dly < 0 means m_done is never given (timeout).
  task automatic txn(input int rdy_dly, input int done_dly, input logic [DW-1:0] rdata,
                     input bit drop, input bit churn, input bit abort, output int w);
    logic [CW-1:0] c;
    logic          err;
    logic [DW-1:0] exp_rd;
    w = winner(req_vld, mptr);
    if (w < 0) begin
      tests++;
      fails++;
      $display("FAIL no_winner: got none want a requester (t=%0t)", $time);
      return;
    end
    // IDLE: Mealy acceptance
    @(negedge clk);
    chk("req_rdy", {60'd0, req_rdy}, {60'd0, onehot(w)});
    chk("busy_idle", {63'd0, busy}, 64'd0);
    c = cmds[w];
    step();
    // ISSUE
    if (drop) req_vld[w] = 1'b0;
    for (int k = 0; k <= rdy_dly; k++) begin
      m_cmd_rdy = (k == rdy_dly);
      if (churn) begin
        req_vld = N'($urandom_range(0, (1 << N) - 1));
        set_cmd($urandom_range(0, N - 1), rand_cmd());
        m_done  = 1'($urandom_range(0, 1));
        m_rdata = $urandom;
      end
      @(negedge clk);
      chk("m_cmd_vld", {63'd0, m_cmd_vld}, 64'd1);
      chk("m_cmd", {19'd0, m_cmd}, {19'd0, c});
      chk("req_rdy_issue", {60'd0, req_rdy}, 64'd0);
      chk("transfer_issue", {63'd0, transfer}, 64'd1);
      chk("grant_id", {62'd0, grant_id}, 64'(w));
      step();
    end
    m_cmd_rdy = 1'b0;
    // WAIT
    for (int k = 0; k < TO; k++) begin
      m_done    = (k == done_dly);
      m_rdata   = (k == done_dly) ? rdata : $urandom;
      m_cmd_rdy = churn ? 1'($urandom_range(0, 1)) : 1'b0;
      if (churn) req_vld = N'($urandom_range(0, (1 << N) - 1));
      if (abort && k == 2) begin
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_outputs_zero("rst_in_wait");
        @(posedge clk);
        #1;
        rst       = 1'b0;
        m_done    = 1'b0;
        m_cmd_rdy = 1'b0;
        req_vld   = '0;
        mptr      = 0;
        exp_q.delete();
        return;
      end
      @(negedge clk);
      chk("transfer_wait", {63'd0, transfer}, 64'd1);
      chk("m_cmd_vld_wait", {63'd0, m_cmd_vld}, 64'd0);
      step();
      if (k == done_dly) break;
    end
    m_done    = 1'b0;
    m_cmd_rdy = 1'b0;
    // RESP: expected response for the monitor, plus timing/phase checks
    err    = (done_dly < 0);
    exp_rd = (err || c[CW-1]) ? '0 : rdata;
    exp_q.push_back({onehot(w), err, exp_rd});
    @(negedge clk);
    chk("rsp_timing", {60'd0, rsp_vld}, {60'd0, onehot(w)});
    chk("transfer_resp", {63'd0, transfer}, 64'd0);
    mptr = (w + 1) % N;
    step();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [RW-1:0] e;
    if (rst !== 1'b1) begin
      if (req_rdy != '0) chk("req_rdy_onehot", 64'($countones(req_rdy)), 64'd1);
      if (rsp_vld != '0) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rsp_unexpected: got rsp_vld=%b want none (t=%0t)", rsp_vld, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rsp", 64'({rsp_vld, rsp_err, rsp_rdata}), 64'(e));
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int dd;
    for (int i = 0; i < N; i++) set_cmd(i, '0);
    do_reset();

    // single write on requester 0
    set_cmd(0, {1'b1, 12'h004, 32'h0000_0004});
    req_vld = 4'b0001;
    txn(0, 1, $urandom, 1'b1, 1'b0, 1'b0, w);

    // all four held: grants 0,1,2,3,0 from a fresh pointer
    do_reset();
    for (int i = 0; i < N; i++) set_cmd(i, rand_cmd());
    req_vld = 4'b1111;
    for (int i = 0; i < 5; i++) txn(0, 0, $urandom, 1'b0, 1'b0, 1'b0, w);
    req_vld = '0;

    // read on requester 2
    set_cmd(2, {1'b0, 12'h008, 32'h1234_5678});
    req_vld = 4'b0100;
    txn(0, 0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, w);

    // master stalls 5 cycles while others keep requesting
    set_cmd(1, {1'b0, 12'h010, 32'h0});
    req_vld = 4'b1011;
    txn(5, 2, $urandom, 1'b1, 1'b0, 1'b0, w);

    // timeout, then m_done coinciding with the last WAIT cycle
    req_vld = 4'b0010;
    txn(0, -1, $urandom, 1'b1, 1'b0, 1'b0, w);
    req_vld = 4'b0001;
    set_cmd(0, {1'b0, 12'h020, 32'h0});
    txn(1, TO - 1, 32'hA5A5_0F0F, 1'b1, 1'b0, 1'b0, w);
    @(negedge clk);
    chk("idle_after_coincide", {63'd0, busy}, 64'd0);
    step();

    // reset while requester 3 is in WAIT; then 1 beats 3 from ptr=0
    req_vld = 4'b1000;
    txn(0, -1, $urandom, 1'b0, 1'b0, 1'b1, w);
    req_vld = 4'b1010;
    txn(0, 0, $urandom, 1'b1, 1'b0, 1'b0, w);
    req_vld = '0;

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        req_vld = '0;
        @(negedge clk);
        chk("idle_no_rdy", {60'd0, req_rdy}, 64'd0);
        chk("idle_busy", {63'd0, busy}, 64'd0);
        step();
      end
      if (req_vld == '0 || $urandom_range(0, 3) == 0)
        req_vld = N'($urandom_range(1, (1 << N) - 1));
      if ($urandom_range(0, 1) == 1) set_cmd($urandom_range(0, N - 1), rand_cmd());
      dd = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      txn($urandom_range(0, 3), dd, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b0, w);
    end

    req_vld = '0;
    repeat (3) step();
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
